vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Raster timing generator sitting directly upstream of the game renderer. It produces the VGA hsync/vsync pair and the current pixel coordinate `x_pixel`/`y_pixel` with an `active_pixels` qualifier. The renderer consumes these to drive `rgb_out`. It also emits frame and vertical-blank strobes so game logic can update state once per frame, outside the visible area.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HSYNC_POL`, 0, asserted level of `hsync` (0 = active-low)
- `VSYNC_POL`, 0, asserted level of `vsync`

Ports:
- `clk` in 1: single system clock
- `rst` in 1: asynchronous, active-high reset
- `pixel_tick` out 1: registered pixel enable; counters advance on `clk` edges where it is 1
- `x_pixel` out 10: horizontal count, 0..H_TOTAL-1
- `y_pixel` out 10: vertical count, 0..V_TOTAL-1
- `active_pixels` out 1: high when `x_pixel < H_ACTIVE` and `y_pixel < V_ACTIVE`
- `hsync` out 1: horizontal sync, polarity per `HSYNC_POL`
- `vsync` out 1: vertical sync, polarity per `VSYNC_POL`
- `frame_start` out 1: one-`clk` pulse when position becomes (0,0)
- `vblank_start` out 1: one-`clk` pulse when position becomes (0,V_ACTIVE)

## Operation
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Horizontal phases by `x_pixel`: ACTIVE 0..639, FRONT 640..655, SYNC 656..751, BACK 752..799. Vertical phases by `y_pixel`: ACTIVE 0..479, FRONT 480..489, SYNC 490..491, BACK 492..524.
- On each tick, `x_pixel` increments. At H_TOTAL-1 it wraps to 0 and `y_pixel` increments. If `y_pixel` is also at V_TOTAL-1, it wraps to 0.
- `hsync` is asserted for x in SYNC. `vsync` is asserted for y in SYNC over whole lines, independent of x.
- All outputs are registered and mutually aligned: `hsync`, `vsync`, `active_pixels` and the strobes always describe the `x_pixel`/`y_pixel` value presented in the same cycle. There is no pipeline skew.
- Strobes are asserted only in the `clk` cycle immediately following the advancing edge. They are never held across non-tick cycles.
- Reset state (all outputs), pre-frame position:
  - `x_pixel` = H_TOTAL-1 (799), `y_pixel` = V_TOTAL-1 (524)
  - `active_pixels` = 0
  - `hsync`/`vsync` deasserted (1 with default polarity)
  - `frame_start` = 0, `vblank_start` = 0, `pixel_tick` = 0
- Reset mid-frame: immediate asynchronous return to the reset state. The next frame always starts cleanly from (0,0).
- Counter widths: 10 bits. Parameter sets with H_TOTAL or V_TOTAL > 1024 are unsupported.

## Timing
- `pixel_tick` leaves reset at 0. The first counter advance happens on the 2nd rising `clk` edge after `rst` deasserts, in both configurations. That advance wraps the counters to (0,0) with `active_pixels`=1 and `frame_start`=1.
- Line period is H_TOTAL ticks. Frame period is H_TOTAL×V_TOTAL ticks = 420000.
- hsync pulse width is H_SYNC ticks (96). vsync pulse width is V_SYNC×H_TOTAL ticks (1600).
- `vblank_start` precedes the next `frame_start` by (V_TOTAL−V_ACTIVE)×H_TOTAL ticks = 36000.

## Configuration
- `VGA_CLK_DIV_EN` defined:
  - `clk` is 2× the pixel rate (50 MHz).
  - An internal toggle, reset to 0, makes `pixel_tick` 1 on every other `clk` cycle.
  - One frame = 840000 `clk`.
- `VGA_CLK_DIV_EN` undefined:
  - `clk` is the pixel clock (25 MHz).
  - `pixel_tick` goes to 1 after the first edge post-reset and stays at 1.
  - One frame = 420000 `clk`.

## Test plan
- Hold `rst`=1 → `x_pixel`=799, `y_pixel`=524, `active_pixels`=0, `hsync`=`vsync`=1, both strobes 0.
- Release reset, count edges → (0,0) with `frame_start`=1 on edge 2. `frame_start` is then 0 for the following 419999 ticks and pulses again.
- Run one line → `hsync` falls when `x_pixel`=656 and rises at 752. `active_pixels` falls at x=640. Line wraps 799→0 with `y_pixel` +1.
- Run one frame → `vblank_start` pulses once at (0,480). `vsync`=0 exactly for y=490..491 (1600 ticks). No `active_pixels` for y≥480.
- Assert `rst` asynchronously at (300,200) for 3 cycles → outputs return to the reset values within the same cycle. After release, the next frame starts at (0,0) two edges later.
- Build with `VGA_CLK_DIV_EN` → `pixel_tick` alternates 0/1, each coordinate holds for 2 `clk`, and the frame period is 840000 `clk`. Without the macro the frame period is 420000 `clk`.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: sync pair, pixel coordinates, active qualifier, frame/vblank strobes.
// Define VGA_CLK_DIV_EN when clk runs at twice the pixel rate.
module vga_timing_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pixel_tick,
  output logic [9:0] x_pixel,
  output logic [9:0] y_pixel,
  output logic       active_pixels,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic       vblank_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] H_SY0  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SY1  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SY0  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SY1  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic       r_tick;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_act;
  logic       r_hs;
  logic       r_vs;
  logic       r_fs;
  logic       r_vb;

  logic       w_x_wrap;
  logic       w_y_wrap;
  logic [9:0] w_x_nxt;
  logic [9:0] w_y_nxt;
  logic       w_act_nxt;
  logic       w_hs_nxt;
  logic       w_vs_nxt;

`ifdef VGA_CLK_DIV_EN
  logic r_toggle;

  // Tick lands on the edge after the toggle reads 0, so the first
  // advance still happens on the 2nd edge out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_toggle <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_toggle <= ~r_toggle;
      r_tick   <= ~r_toggle;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b1;
    end
  end
`endif

  always_comb begin
    w_x_wrap  = (r_x == H_LAST);
    w_y_wrap  = (r_y == V_LAST);
    w_x_nxt   = w_x_wrap ? 10'd0 : r_x + 10'd1;
    w_y_nxt   = r_y;
    if (w_x_wrap) begin
      w_y_nxt = w_y_wrap ? 10'd0 : r_y + 10'd1;
    end
    w_act_nxt = (w_x_nxt < H_ACT) && (w_y_nxt < V_ACT);
    w_hs_nxt  = (w_x_nxt >= H_SY0) && (w_x_nxt <= H_SY1);
    w_vs_nxt  = (w_y_nxt >= V_SY0) && (w_y_nxt <= V_SY1);
  end

  // Flags are computed from the next position so every output
  // describes the coordinate presented alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x   <= H_LAST;
      r_y   <= V_LAST;
      r_act <= 1'b0;
      r_hs  <= ~HSYNC_POL;
      r_vs  <= ~VSYNC_POL;
      r_fs  <= 1'b0;
      r_vb  <= 1'b0;
    end else begin
      r_fs <= 1'b0;
      r_vb <= 1'b0;
      if (r_tick) begin
        r_x   <= w_x_nxt;
        r_y   <= w_y_nxt;
        r_act <= w_act_nxt;
        r_hs  <= w_hs_nxt ? HSYNC_POL : ~HSYNC_POL;
        r_vs  <= w_vs_nxt ? VSYNC_POL : ~VSYNC_POL;
        r_fs  <= (w_x_nxt == 10'd0) && (w_y_nxt == 10'd0);
        r_vb  <= (w_x_nxt == 10'd0) && (w_y_nxt == V_ACT);
      end
    end
  end

  assign pixel_tick    = r_tick;
  assign x_pixel       = r_x;
  assign y_pixel       = r_y;
  assign active_pixels = r_act;
  assign hsync         = r_hs;
  assign vsync         = r_vs;
  assign frame_start   = r_fs;
  assign vblank_start  = r_vb;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing plus a tiny raster (16x12, hsync active-high).
module tb_vga_timing_gen;

`ifdef VGA_CLK_DIV_EN
  localparam int CPT = 2;
`else
  localparam int CPT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       d_tick, d_act, d_hs, d_vs, d_fs, d_vb;
  logic [9:0] d_x, d_y;
  logic       s_tick, s_act, s_hs, s_vs, s_fs, s_vb;
  logic [9:0] s_x, s_y;

  int n_chk  = 0;
  int n_fail = 0;
  int t      = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .pixel_tick(d_tick),
    .x_pixel(d_x), .y_pixel(d_y), .active_pixels(d_act),
    .hsync(d_hs), .vsync(d_vs),
    .frame_start(d_fs), .vblank_start(d_vb)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) u_sml (
    .clk(clk), .rst(rst), .pixel_tick(s_tick),
    .x_pixel(s_x), .y_pixel(s_y), .active_pixels(s_act),
    .hsync(s_hs), .vsync(s_vs),
    .frame_start(s_fs), .vblank_start(s_vb)
  );

  task automatic adv();
    repeat (CPT) @(posedge clk);
    #1;
    t++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (d_x !== 10'd799) begin n_fail++; $display("FAIL rst_x got %0d exp 799", d_x); end
    n_chk++; if (d_y !== 10'd524) begin n_fail++; $display("FAIL rst_y got %0d exp 524", d_y); end
    n_chk++; if (d_act !== 1'b0) begin n_fail++; $display("FAIL rst_act got %b exp 0", d_act); end
    n_chk++; if (d_hs !== 1'b1) begin n_fail++; $display("FAIL rst_hs got %b exp 1", d_hs); end
    n_chk++; if (d_vs !== 1'b1) begin n_fail++; $display("FAIL rst_vs got %b exp 1", d_vs); end
    n_chk++; if (d_fs !== 1'b0) begin n_fail++; $display("FAIL rst_fs got %b exp 0", d_fs); end
    n_chk++; if (d_vb !== 1'b0) begin n_fail++; $display("FAIL rst_vb got %b exp 0", d_vb); end
    n_chk++; if (d_tick !== 1'b0) begin n_fail++; $display("FAIL rst_tick got %b exp 0", d_tick); end
    n_chk++; if (s_x !== 10'd15) begin n_fail++; $display("FAIL rst_sx got %0d exp 15", s_x); end
    n_chk++; if (s_y !== 10'd11) begin n_fail++; $display("FAIL rst_sy got %0d exp 11", s_y); end
    n_chk++; if (s_hs !== 1'b0) begin n_fail++; $display("FAIL rst_shs got %b exp 0", s_hs); end
    n_chk++; if (s_vs !== 1'b1) begin n_fail++; $display("FAIL rst_svs got %b exp 1", s_vs); end
  endtask

  task automatic test_start();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (d_tick !== 1'b1) begin n_fail++; $display("FAIL e1_tick got %b exp 1", d_tick); end
    n_chk++; if (d_x !== 10'd799) begin n_fail++; $display("FAIL e1_x got %0d exp 799", d_x); end
    n_chk++; if (d_fs !== 1'b0) begin n_fail++; $display("FAIL e1_fs got %b exp 0", d_fs); end
    @(posedge clk); #1;
    t = 0;
    n_chk++; if (d_x !== 10'd0) begin n_fail++; $display("FAIL e2_x got %0d exp 0", d_x); end
    n_chk++; if (d_y !== 10'd0) begin n_fail++; $display("FAIL e2_y got %0d exp 0", d_y); end
    n_chk++; if (d_act !== 1'b1) begin n_fail++; $display("FAIL e2_act got %b exp 1", d_act); end
    n_chk++; if (d_fs !== 1'b1) begin n_fail++; $display("FAIL e2_fs got %b exp 1", d_fs); end
    n_chk++; if (s_x !== 10'd0) begin n_fail++; $display("FAIL e2_sx got %0d exp 0", s_x); end
    n_chk++; if (s_fs !== 1'b1) begin n_fail++; $display("FAIL e2_sfs got %b exp 1", s_fs); end
`ifdef VGA_CLK_DIV_EN
    @(posedge clk); #1;
    n_chk++; if (d_tick !== 1'b1) begin n_fail++; $display("FAIL e3_tick got %b exp 1", d_tick); end
    n_chk++; if (d_x !== 10'd0) begin n_fail++; $display("FAIL e3_hold_x got %0d exp 0", d_x); end
    n_chk++; if (d_fs !== 1'b0) begin n_fail++; $display("FAIL e3_fs got %b exp 0", d_fs); end
    @(posedge clk); #1;
    t = 1;
    n_chk++; if (d_tick !== 1'b0) begin n_fail++; $display("FAIL e4_tick got %b exp 0", d_tick); end
    n_chk++; if (d_x !== 10'd1) begin n_fail++; $display("FAIL e4_x got %0d exp 1", d_x); end
`endif
  endtask

  task automatic test_line();
    int ex, ey, hs_low;
    hs_low = 0;
    for (int i = 0; i < 800; i++) begin
      adv();
      ex = t % 800;
      ey = (t / 800) % 525;
      if (d_hs == 1'b0) hs_low++;
      n_chk++;
      if (d_x !== 10'(ex) || d_y !== 10'(ey)) begin
        n_fail++; $display("FAIL line_pos t=%0d got (%0d,%0d) exp (%0d,%0d)", t, d_x, d_y, ex, ey);
      end
      n_chk++;
      if (d_hs !== !(ex >= 656 && ex <= 751)) begin
        n_fail++; $display("FAIL line_hs x=%0d got %b", ex, d_hs);
      end
      n_chk++;
      if (d_act !== (ex < 640 && ey < 480)) begin
        n_fail++; $display("FAIL line_act x=%0d got %b", ex, d_act);
      end
      n_chk++;
      if (d_fs !== 1'b0 || d_vb !== 1'b0) begin
        n_fail++; $display("FAIL line_strobe x=%0d got fs=%b vb=%b exp 0", ex, d_fs, d_vb);
      end
    end
    n_chk++;
    if (hs_low != 96) begin n_fail++; $display("FAIL hs_width got %0d exp 96", hs_low); end
  endtask

  task automatic test_frame();
    int sx, sy, vs_low, n_fs, n_vb;
    while (t % 192 != 0) adv();
    n_chk++; if (s_fs !== 1'b1) begin n_fail++; $display("FAIL frm_fs0 got %b exp 1", s_fs); end
    vs_low = 0; n_fs = 0; n_vb = 0;
    for (int i = 0; i < 192; i++) begin
      adv();
      sx = t % 16;
      sy = (t / 16) % 12;
      if (s_vs == 1'b0) vs_low++;
      if (s_fs) n_fs++;
      if (s_vb) n_vb++;
      n_chk++;
      if (s_x !== 10'(sx) || s_y !== 10'(sy)) begin
        n_fail++; $display("FAIL frm_pos t=%0d got (%0d,%0d) exp (%0d,%0d)", t, s_x, s_y, sx, sy);
      end
      n_chk++;
      if (s_act !== (sx < 8 && sy < 6)) begin
        n_fail++; $display("FAIL frm_act (%0d,%0d) got %b", sx, sy, s_act);
      end
      n_chk++;
      if (s_hs !== (sx >= 10 && sx <= 12)) begin
        n_fail++; $display("FAIL frm_hs (%0d,%0d) got %b", sx, sy, s_hs);
      end
      n_chk++;
      if (s_vs !== !(sy >= 8 && sy <= 9)) begin
        n_fail++; $display("FAIL frm_vs (%0d,%0d) got %b", sx, sy, s_vs);
      end
      n_chk++;
      if (s_fs !== (sx == 0 && sy == 0) || s_vb !== (sx == 0 && sy == 6)) begin
        n_fail++; $display("FAIL frm_strobe (%0d,%0d) got fs=%b vb=%b", sx, sy, s_fs, s_vb);
      end
    end
    n_chk++; if (vs_low != 32) begin n_fail++; $display("FAIL vs_width got %0d exp 32", vs_low); end
    n_chk++; if (n_fs != 1) begin n_fail++; $display("FAIL fs_count got %0d exp 1", n_fs); end
    n_chk++; if (n_vb != 1) begin n_fail++; $display("FAIL vb_count got %0d exp 1", n_vb); end
  endtask

  task automatic test_reset_mid();
    repeat (37) adv();
    #2;
    rst = 1'b1;
    #1;
    n_chk++; if (d_x !== 10'd799 || d_y !== 10'd524) begin
      n_fail++; $display("FAIL arst_pos got (%0d,%0d) exp (799,524)", d_x, d_y); end
    n_chk++; if (d_act !== 1'b0 || d_hs !== 1'b1 || d_vs !== 1'b1) begin
      n_fail++; $display("FAIL arst_flags got act=%b hs=%b vs=%b exp 0,1,1", d_act, d_hs, d_vs); end
    n_chk++; if (d_tick !== 1'b0) begin n_fail++; $display("FAIL arst_tick got %b exp 0", d_tick); end
    n_chk++; if (s_x !== 10'd15 || s_y !== 10'd11) begin
      n_fail++; $display("FAIL arst_spos got (%0d,%0d) exp (15,11)", s_x, s_y); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (d_x !== 10'd799) begin n_fail++; $display("FAIL rel_e1_x got %0d exp 799", d_x); end
    @(posedge clk); #1;
    n_chk++; if (d_x !== 10'd0 || d_y !== 10'd0) begin
      n_fail++; $display("FAIL rel_e2_pos got (%0d,%0d) exp (0,0)", d_x, d_y); end
    n_chk++; if (d_fs !== 1'b1 || s_fs !== 1'b1) begin
      n_fail++; $display("FAIL rel_e2_fs got %b/%b exp 1/1", d_fs, s_fs); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_line();
    test_frame();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
